// File: rtl/switch_box_nxn_reg_if.sv
// Bus bundle for the registered N x N switch box: configuration port plus
// the flat per-port data/valid vectors.
//
// Handshake: a configuration write transfers on a rising edge where
// conf_valid && conf_ready are both high; conf_ready drops once the shadow
// holds a full set. conf_commit takes effect only while conf_loaded is high.
// The data path has no handshake: in_valid/in_data are sampled every cycle.
interface switch_box_nxn_reg_if #(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 16
);
  localparam int SEL_W = $clog2(N_PORTS);

  logic                       conf_valid;
  logic [SEL_W:0]             conf_data;
  logic                       conf_ready;
  logic                       conf_commit;
  logic                       conf_loaded;
  logic [N_PORTS-1:0]         in_valid;
  logic [N_PORTS*WIDTH-1:0]   in_data;
  logic [N_PORTS-1:0]         out_valid;
  logic [N_PORTS*WIDTH-1:0]   out_data;

  modport master (
    output conf_valid, conf_data, conf_commit, in_valid, in_data,
    input  conf_ready, conf_loaded, out_valid, out_data
  );

  modport slave (
    input  conf_valid, conf_data, conf_commit, in_valid, in_data,
    output conf_ready, conf_loaded, out_valid, out_data
  );
endinterface

// File: rtl/switch_box_nxn_reg.sv
// Registered, runtime-reconfigurable N x N switch box. Each output picks any
// input or is disabled. Routing lives in a double-buffered config: the shadow
// is filled one output per accepted write, then copied to the active set in
// one edge so routes never change halfway through a reconfiguration.
module switch_box_nxn_reg #(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  switch_box_nxn_reg_if.slave bus
);
  localparam int SEL_W = $clog2(N_PORTS);
  localparam logic [SEL_W-1:0] WP_LAST = SEL_W'(N_PORTS - 1);

  // Active and shadow routing tables
  logic [N_PORTS-1:0]            en_a_q, en_a_d;
  logic [N_PORTS-1:0][SEL_W-1:0] sel_a_q, sel_a_d;
  logic [N_PORTS-1:0]            en_s_q, en_s_d;
  logic [N_PORTS-1:0][SEL_W-1:0] sel_s_q, sel_s_d;
  logic [SEL_W-1:0]              wp_q, wp_d;
  logic                          loaded_q, loaded_d;

  // Registered outputs
  logic [N_PORTS-1:0]            out_valid_q, out_valid_d;
  logic [N_PORTS*WIDTH-1:0]      out_data_q, out_data_d;

  logic [WIDTH-1:0]              in_arr [N_PORTS];
  logic [N_PORTS-1:0]            in_range;
  logic [N_PORTS-1:0]            eff;
  logic                          cfg_accept;
  logic                          cfg_commit;

  // Writes and commits are mutually exclusive: one needs !loaded, the other loaded
  assign cfg_accept = bus.conf_valid && !loaded_q;
  assign cfg_commit = bus.conf_commit && loaded_q;

  assign bus.conf_ready  = !loaded_q;
  assign bus.conf_loaded = loaded_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;

  // A select beyond the port count (only possible when N is not a power of 2) disables the output
  for (genvar j = 0; j < N_PORTS; j++) begin : g_range
    if ((1 << SEL_W) == N_PORTS) begin : g_pow2
      assign in_range[j] = 1'b1;
    end else begin : g_cmp
      assign in_range[j] = ({1'b0, sel_a_q[j]} < (SEL_W+1)'(N_PORTS));
    end
  end

  assign eff = en_a_q & in_range;

  // Unpack the flat input bus so ports can be indexed by select value
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      in_arr[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Shadow fill, write pointer and atomic commit into the active table
  always_comb begin
    en_a_d   = en_a_q;
    sel_a_d  = sel_a_q;
    en_s_d   = en_s_q;
    sel_s_d  = sel_s_q;
    wp_d     = wp_q;
    loaded_d = loaded_q;
    if (cfg_commit) begin
      en_a_d   = en_s_q;
      sel_a_d  = sel_s_q;
      loaded_d = 1'b0;
    end
    if (cfg_accept) begin
      en_s_d[wp_q]  = bus.conf_data[SEL_W];
      sel_s_d[wp_q] = bus.conf_data[SEL_W-1:0];
      if (wp_q == WP_LAST) begin
        wp_d     = '0;
        loaded_d = 1'b1;
      end else begin
        wp_d = wp_q + 1'b1;
      end
    end
  end

  // Crossbar: enabled outputs follow their input; disabled ones drop valid and hold data
  always_comb begin
    out_valid_d = '0;
    out_data_d  = out_data_q;
    for (int j = 0; j < N_PORTS; j++) begin
      if (eff[j]) begin
        out_valid_d[j]                = bus.in_valid[sel_a_q[j]];
        out_data_d[j*WIDTH +: WIDTH]  = in_arr[sel_a_q[j]];
      end
    end
  end

  // State registers; reset clears both tables and the outputs at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_a_q      <= '0;
      sel_a_q     <= '0;
      en_s_q      <= '0;
      sel_s_q     <= '0;
      wp_q        <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      en_a_q      <= en_a_d;
      sel_a_q     <= sel_a_d;
      en_s_q      <= en_s_d;
      sel_s_q     <= sel_s_d;
      wp_q        <= wp_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_switch_box_nxn_reg.sv
// Directed bench for switch_box_nxn_reg with N_PORTS=4, WIDTH=16.
module tb_switch_box_nxn_reg;
  localparam int N = 4;
  localparam int W = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_box_nxn_reg_if #(.N_PORTS(N), .WIDTH(W)) bus ();

  switch_box_nxn_reg #(.N_PORTS(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: everything changes 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [1:0] sel);
    bus.conf_valid = 1'b1;
    bus.conf_data  = {en, sel};
    tick();
    bus.conf_valid = 1'b0;
  endtask

  task automatic cm();
    bus.conf_commit = 1'b1;
    tick();
    bus.conf_commit = 1'b0;
  endtask

  task automatic drive(input logic [3:0] v, input logic [63:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  initial begin
    bus.conf_valid  = 1'b0;
    bus.conf_data   = '0;
    bus.conf_commit = 1'b0;
    drive(4'hF, 64'h1234_5678_9ABC_DEF0);

    // Reset: no config, inputs all valid
    #12;
    check("rst_out_valid", {60'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_ready", {63'd0, bus.conf_ready}, 64'd1);
    check("rst_loaded", {63'd0, bus.conf_loaded}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_out_valid", {60'd0, bus.out_valid}, 64'd0);
    check("idle_out_data", bus.out_data, 64'd0);
    check("idle_ready", {63'd0, bus.conf_ready}, 64'd1);

    // Permutation
    wr(1'b1, 2'd3); wr(1'b1, 2'd0); wr(1'b1, 2'd2);
    check("perm_loaded_3", {63'd0, bus.conf_loaded}, 64'd0);
    wr(1'b1, 2'd1);
    check("perm_loaded_4", {63'd0, bus.conf_loaded}, 64'd1);
    check("perm_ready_4", {63'd0, bus.conf_ready}, 64'd0);
    drive(4'hF, 64'hA003_A002_A001_A000);
    cm();
    check("perm_commit_loaded", {63'd0, bus.conf_loaded}, 64'd0);
    check("perm_commit_edge_valid", {60'd0, bus.out_valid}, 64'd0);
    check("perm_commit_edge_data", bus.out_data, 64'd0);
    tick();
    check("perm_out_data", bus.out_data, 64'hA001_A002_A000_A003);
    check("perm_out_valid", {60'd0, bus.out_valid}, 64'hF);

    // Ignored commit after partial load, then overflowed write
    wr(1'b1, 2'd0); wr(1'b1, 2'd0);
    check("part_loaded", {63'd0, bus.conf_loaded}, 64'd0);
    drive(4'b1110, 64'h1113_1112_1111_1110);
    cm();
    check("part_commit_loaded", {63'd0, bus.conf_loaded}, 64'd0);
    check("part_old_route_data", bus.out_data, 64'h1111_1112_1110_1113);
    check("part_old_route_valid", {60'd0, bus.out_valid}, 64'b1101);
    wr(1'b1, 2'd0);
    check("ovf_loaded_3", {63'd0, bus.conf_loaded}, 64'd0);
    wr(1'b1, 2'd0);
    check("ovf_loaded_4", {63'd0, bus.conf_loaded}, 64'd1);
    wr(1'b1, 2'd2);
    check("ovf_ready", {63'd0, bus.conf_ready}, 64'd0);
    check("ovf_loaded_5", {63'd0, bus.conf_loaded}, 64'd1);
    cm();
    check("ovf_commit_ready", {63'd0, bus.conf_ready}, 64'd1);
    tick();
    check("ovf_out_data", bus.out_data, 64'h1110_1110_1110_1110);
    check("ovf_out_valid", {60'd0, bus.out_valid}, 64'd0);

    // Atomic switch: out0 moves from in0 to in1 at the commit edge
    wr(1'b1, 2'd1); wr(1'b0, 2'd0); wr(1'b0, 2'd0); wr(1'b0, 2'd0);
    check("atom_loaded", {63'd0, bus.conf_loaded}, 64'd1);
    for (int c = 0; c < 6; c++) begin
      drive(4'b0011, {32'd0, (16'h8000 | 16'(c)), 16'(c)});
      bus.conf_commit = (c == 2);
      tick();
      bus.conf_commit = 1'b0;
      check($sformatf("atom_out0_c%0d", c), {48'd0, bus.out_data[15:0]},
            (c <= 2) ? 64'(c) : 64'(16'h8000 | 16'(c)));
      check($sformatf("atom_v0_c%0d", c), {63'd0, bus.out_valid[0]}, 64'd1);
    end

    // Fan-out of in1 to out0/out2, out1 and out3 disabled and frozen
    wr(1'b1, 2'd1); wr(1'b0, 2'd0); wr(1'b1, 2'd1); wr(1'b0, 2'd0);
    cm();
    drive(4'b0010, 64'h0000_0000_B001_0000);
    tick();
    check("fan_v_1", {60'd0, bus.out_valid}, 64'b0101);
    check("fan_d_1", bus.out_data, 64'h0002_B001_0002_B001);
    drive(4'b0000, 64'h0000_0000_B002_0000);
    tick();
    check("fan_v_2", {60'd0, bus.out_valid}, 64'b0000);
    check("fan_d_2", bus.out_data, 64'h0002_B002_0002_B002);
    drive(4'b0010, 64'h0000_0000_B003_0000);
    tick();
    check("fan_v_3", {60'd0, bus.out_valid}, 64'b0101);
    check("fan_d_3", bus.out_data, 64'h0002_B003_0002_B003);

    // Asynchronous reset in the middle of a load
    wr(1'b1, 2'd2); wr(1'b1, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {60'd0, bus.out_valid}, 64'd0);
    check("arst_out_data", bus.out_data, 64'd0);
    check("arst_ready", {63'd0, bus.conf_ready}, 64'd1);
    #1;
    rst_n = 1'b1;
    wr(1'b1, 2'd0); wr(1'b1, 2'd1);
    check("arst_loaded_2", {63'd0, bus.conf_loaded}, 64'd0);
    drive(4'hF, 64'hC003_C002_C001_C000);
    cm();
    check("arst_commit_ign", {63'd0, bus.conf_loaded}, 64'd0);
    check("arst_still_off", {60'd0, bus.out_valid}, 64'd0);
    wr(1'b1, 2'd0); wr(1'b1, 2'd1);
    check("arst_loaded_4", {63'd0, bus.conf_loaded}, 64'd1);
    cm();
    check("arst_commit_loaded", {63'd0, bus.conf_loaded}, 64'd0);
    check("arst_commit_edge_valid", {60'd0, bus.out_valid}, 64'd0);
    tick();
    check("arst_out_data_new", bus.out_data, 64'hC001_C000_C001_C000);
    check("arst_out_valid_new", {60'd0, bus.out_valid}, 64'hF);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
